// File: rtl/register_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : register_dump_reader
// Description : Walks the register bank through one read port and streams
//               every word MSB byte first on a valid/ready byte interface.
// Revision    : 1.0 - initial release
// ============================================================================
module register_dump_reader #(
    parameter int NB_DATA     = 32,
    parameter int NB_ADDRESS  = 5,
    parameter int N_REGISTERS = 32,
    parameter int NB_BYTE     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    output logic [NB_ADDRESS-1:0] o_rd_addr,
    input  logic [NB_DATA-1:0]    i_rd_data,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int c_N_BYTES = NB_DATA / NB_BYTE;
    localparam int c_NB_CNT  = (c_N_BYTES > 1) ? $clog2(c_N_BYTES) : 1;
    localparam logic [c_NB_CNT-1:0]   c_LAST_BYTE = c_NB_CNT'(c_N_BYTES - 1);
    localparam logic [NB_ADDRESS-1:0] c_LAST_REG  = NB_ADDRESS'(N_REGISTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [NB_DATA-1:0]    r_shift;
    logic [c_NB_CNT-1:0]   r_byte_cnt;
    logic [NB_ADDRESS-1:0] r_rd_addr;
    logic                  w_xfer;
    logic                  w_last_byte;
    logic                  w_last_reg;

    assign w_xfer      = (r_state == ST_SEND) && i_tx_ready;
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);
    assign w_last_reg  = (r_rd_addr == c_LAST_REG);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next_state = ST_LOAD;
            ST_LOAD: w_next_state = ST_SEND;
            ST_SEND: begin
                if (w_xfer && w_last_byte) begin
                    w_next_state = w_last_reg ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        // Abort overrides everything, including a start or a transfer in the same cycle.
        if (i_abort) w_next_state = ST_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_rd_addr  <= '0;
        end else if (i_abort) begin
            r_byte_cnt <= '0;
            r_rd_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start) r_rd_addr <= '0;
                ST_LOAD: begin
                    r_shift    <= i_rd_data;
                    r_byte_cnt <= '0;
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        if (!w_last_byte) begin
                            r_shift    <= r_shift << NB_BYTE;
                            r_byte_cnt <= r_byte_cnt + c_NB_CNT'(1);
                        end else if (!w_last_reg) begin
                            r_rd_addr <= r_rd_addr + NB_ADDRESS'(1);
                        end
                    end
                end
                ST_DONE: r_rd_addr <= '0;
                default: r_rd_addr <= '0;
            endcase
        end
    end

    // Stream outputs decode straight from registered state, so reset clears them at once.
    assign o_rd_addr  = r_rd_addr;
    assign o_tx_data  = r_shift[NB_DATA-1 -: NB_BYTE];
    assign o_tx_valid = (r_state == ST_SEND);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_register_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_dump_reader
// Description : Randomized scoreboard bench for register_dump_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_dump_reader;

    localparam int NB_DATA     = 32;
    localparam int NB_ADDRESS  = 5;
    localparam int N_REGISTERS = 32;
    localparam int NB_BYTE     = 8;
    localparam int N_BYTES     = NB_DATA / NB_BYTE;

    logic                  clk      = 1'b0;
    logic                  rst_n    = 1'b1;
    logic                  start    = 1'b0;
    logic                  abort    = 1'b0;
    logic                  tx_ready = 1'b0;
    logic [NB_ADDRESS-1:0] rd_addr;
    logic [NB_DATA-1:0]    rd_data;
    logic [NB_BYTE-1:0]    tx_data;
    logic                  tx_valid;
    logic                  busy;
    logic                  done;

    logic [NB_DATA-1:0] bank [0:N_REGISTERS-1];
    assign rd_data = bank[rd_addr];

    register_dump_reader #(
        .NB_DATA    (NB_DATA),
        .NB_ADDRESS (NB_ADDRESS),
        .N_REGISTERS(N_REGISTERS),
        .NB_BYTE    (NB_BYTE)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_start   (start),
        .i_abort   (abort),
        .o_rd_addr (rd_addr),
        .i_rd_data (rd_data),
        .o_tx_data (tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready),
        .o_busy    (busy),
        .o_done    (done)
    );

    always #5 clk = ~clk;

    int           n_checks   = 0;
    int           n_fail     = 0;
    logic [7:0]   exp_q[$];
    int           n_rx       = 0;
    int           done_cnt   = 0;
    int           cyc        = 0;
    int           start_cyc  = 0;
    bit           time_chk   = 1'b0;
    int           ready_mode = 2;
    bit           stall_prev = 1'b0;
    logic [7:0]   stall_data = '0;
    bit           done_prev  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: a dump is every register in address order, each MSB byte first.
    task automatic push_dump();
        for (int r = 0; r < N_REGISTERS; r++) begin
            for (int b = 0; b < N_BYTES; b++) begin
                exp_q.push_back(8'((bank[r] >> (NB_DATA - NB_BYTE * (b + 1))) & 32'hFF));
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0)      tx_ready = 1'b1;
        else if (ready_mode == 1) tx_ready = ($urandom_range(0, 99) < 30);
    end

    // Monitor: pops expected bytes on every accepted transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(stall_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h, expected no byte", tx_data);
                end else begin
                    check($sformatf("byte%0d", n_rx), 32'(tx_data), 32'(exp_q.pop_front()));
                end
                n_rx++;
            end
            if (done_prev) begin
                check("done_one_cycle", 32'(done), 32'd0);
                check("busy_after_done", 32'(busy), 32'd0);
            end
            if (done) begin
                done_cnt++;
                if (time_chk) check("done_latency", 32'(cyc - start_cyc), 32'd161);
                check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            done_prev  = done;
        end else begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end
    end

    task automatic do_start();
        @(posedge clk); #2;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_done, input int budget);
        int k = 0;
        while (done_cnt < exp_done && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("done_count", 32'(done_cnt), 32'(exp_done));
    endtask

    task automatic wait_rx(input int target, input int budget);
        int k = 0;
        @(posedge clk); #2;
        while (!(n_rx == target && tx_valid) && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        check("reach_byte", 32'(n_rx), 32'(target));
    endtask

    initial begin
        int bad;
        for (int k = 0; k < N_REGISTERS; k++) bank[k] = $urandom;

        // Reset held with random inputs: every output stays zero.
        #1 rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            start    = 1'($urandom);
            abort    = 1'($urandom);
            tx_ready = 1'($urandom);
            @(negedge clk);
            check("reset_outputs", {rd_addr, tx_data, tx_valid, busy, done}, 32'd0);
        end
        @(posedge clk); #2;
        start = 1'b0; abort = 1'b0; rst_n = 1'b1;
        ready_mode = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid || busy) bad++;
        end
        check("idle_after_reset", 32'(bad), 32'd0);

        // Full dump with ready always high, known pattern.
        for (int k = 0; k < N_REGISTERS; k++) bank[k] = 32'h0A0B0C00 + k;
        push_dump();
        n_rx = 0;
        time_chk = 1'b1;
        do_start();
        wait_done(1, 400);
        time_chk = 1'b0;
        check("full_dump_bytes", 32'(n_rx), 32'd128);

        // Backpressure with random data.
        for (int k = 0; k < N_REGISTERS; k++) bank[k] = $urandom;
        ready_mode = 1;
        push_dump();
        n_rx = 0;
        do_start();
        wait_done(2, 3000);
        check("backpressure_bytes", 32'(n_rx), 32'd128);

        // Second start while busy is ignored.
        for (int k = 0; k < N_REGISTERS; k++) bank[k] = $urandom;
        ready_mode = 0;
        push_dump();
        n_rx = 0;
        do_start();
        wait_rx(10, 200);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(3, 400);
        repeat (10) @(posedge clk);
        check("start_busy_bytes", 32'(n_rx), 32'd128);
        check("start_busy_dones", 32'(done_cnt), 32'd3);

        // Abort coincident with the transfer of byte 50.
        for (int k = 0; k < N_REGISTERS; k++) bank[k] = 32'h0A0B0C00 + k;
        push_dump();
        n_rx = 0;
        do_start();
        wait_rx(50, 200);
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_valid", 32'(tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (20) @(posedge clk);
        check("abort_bytes", 32'(n_rx), 32'd51);
        check("abort_no_done", 32'(done_cnt), 32'd3);

        // Restart after abort begins again from register 0.
        push_dump();
        n_rx = 0;
        do_start();
        wait_done(4, 400);
        check("restart_bytes", 32'(n_rx), 32'd128);

        // Asynchronous reset mid-dump.
        for (int k = 0; k < N_REGISTERS; k++) bank[k] = $urandom;
        ready_mode = 1;
        push_dump();
        n_rx = 0;
        do_start();
        wait_rx(20, 1000);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {rd_addr, tx_data, tx_valid, busy, done}, 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        stall_prev = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid || busy) bad++;
        end
        check("idle_after_async_reset", 32'(bad), 32'd0);
        check("async_reset_no_done", 32'(done_cnt), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
